bill_accumulator: RTL and testbench
===================================

// Module: bill_accumulator
// PURPOSE
//  Upstream stage of the discount path. Accepts priced line items (price x qty) one at a time.
//  Multiplies each item with a sequential shift-add and accumulates a saturating 13-bit bill total.
//  On bill close it presents total[12:0] plus the discount enable that drive the divide-by-4 discount stage.
//  That stage takes the total on its a input and disc_en on its ed input.
// PARAMETERS
//  PRICE_W      8     item price width (unsigned)
//  QTY_W        4     item quantity width (unsigned); also the multiply cycle count
//  TOT_W        13    total width; must match the discount stage input width
//  DISC_THRESH  2000  disc_en asserts when the closed total >= this value
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  item_valid   in   1        item_price/item_qty valid this cycle
//  item_price   in   PRICE_W  unit price
//  item_qty     in   QTY_W    quantity; 0 is legal and adds 0
//  item_ready   out  1        high only in IDLE; transfer = item_valid & item_ready
//  bill_close   in   1        request to finish the bill (single-cycle pulse or level)
//  total        out  TOT_W    running/closed total
//  total_valid  out  1        closed total presented; held until out_ack
//  disc_en      out  1        total_valid & (total >= DISC_THRESH)
//  overflow     out  1        sticky: a saturation occurred in this bill
//  out_ack      in   1        consumer accepted the closed bill
// BEHAVIOUR
//  Reset: state=IDLE, total=0, product=0, close_pend=0.
//   total_valid, disc_en and overflow are 0; item_ready is 0 while rst is high.
//  Clock-to-output timing:
//   - item_ready is combinational from state.
//   - All other outputs come from registers.
//   - disc_en is registered together with total_valid.
//  States:
//   - IDLE: item_ready=1.
//     - Item transfer: latch price and qty, clear product and cnt, go to MUL.
//     - Item transfer with bill_close in the same cycle: also set close_pend.
//     - bill_close with no transfer: go to DONE.
//   - MUL (exactly QTY_W cycles, cnt = 0..QTY_W-1): if qty[cnt]=1, product += price << cnt.
//     - product is PRICE_W+QTY_W bits wide and never overflows.
//   - ADD (1 cycle): compute the sum total+product at TOT_W+1 bits.
//     - If the sum > 2^TOT_W-1: total = 8191 and overflow is set.
//     - Otherwise total = the sum.
//     - Next state is DONE if close_pend, else IDLE. close_pend is cleared.
//   - bill_close during MUL/ADD sets close_pend; it is never lost.
//   - DONE: total_valid=1; disc_en is computed on entry and held.
//     - total is frozen; item_valid and bill_close are ignored.
//     - On out_ack: total=0, overflow=0, total_valid=0, disc_en=0, go to IDLE.
//  Latency: item transferred at edge N -> total updated at edge N+QTY_W+1 (N+5 by default).
//  Next item accepted at edge N+QTY_W+2.
//  Closing an empty bill gives total=0, total_valid=1, disc_en=0.
//  Saturation is sticky: once total=8191, further items keep 8191.
//  rst in any state, including mid-MUL, returns to the reset values next edge; the partial item is discarded.
//  Throughput: one item per QTY_W+2 cycles.
// TESTING
//  1. price=100, qty=3, then close -> total=300 exactly 5 cycles after transfer.
//     Then total_valid=1, disc_en=0, overflow=0.
//  2. Items (250,4), (200,5), (100,1), then close -> total=2100, disc_en=1.
//     The downstream discount output is 525; out_ack clears total to 0.
//  3. Three items (255,15) -> totals 3825, 7650, then saturate at 8191 with overflow=1.
//     A fourth item keeps 8191.
//  4. bill_close with item_valid in the same IDLE cycle (price 10, qty 2).
//     -> Item is added, total=20, DONE entered with no second close.
//  5. Close with no items -> total_valid=1, total=0.
//     item_valid during DONE -> item_ready=0, no change; ack -> IDLE.
//  6. rst asserted on the 2nd MUL cycle of (50,7) -> next cycle: IDLE, total=0, item_ready=1 after rst drops.

Source files
------------

// File: rtl/bill_accumulator.sv
// Accumulates priced line items (price x qty, sequential shift-add) into a saturating bill total
// and presents the closed total with a discount enable for the downstream divide-by-4 stage.
module bill_accumulator #(
    parameter int PRICE_W     = 8,
    parameter int QTY_W       = 4,
    parameter int TOT_W       = 13,
    parameter int DISC_THRESH = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               item_valid,
    input  logic [PRICE_W-1:0] item_price,
    input  logic [QTY_W-1:0]   item_qty,
    output logic               item_ready,
    input  logic               bill_close,
    output logic [TOT_W-1:0]   total,
    output logic               total_valid,
    output logic               disc_en,
    output logic               overflow,
    input  logic               out_ack
);

    localparam int PROD_W = PRICE_W + QTY_W;
    localparam int CNT_W  = (QTY_W > 1) ? $clog2(QTY_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QTY_W - 1);
    localparam logic [TOT_W-1:0] TOT_MAX  = '1;
    localparam logic [TOT_W-1:0] THRESH   = TOT_W'(DISC_THRESH);

    // Handshake: an item transfers on a rising edge where item_valid && item_ready; item_ready is
    // high only in IDLE. The closed bill is held (total_valid) until out_ack is seen in DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [PROD_W-1:0]  product_q, product_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic               close_pend_q, close_pend_d;
    logic               overflow_q, overflow_d;
    logic               total_valid_q, total_valid_d;
    logic               disc_en_q, disc_en_d;

    logic [TOT_W:0]     sum;
    logic [PROD_W-1:0]  addend;

    always_comb begin
        state_d       = state_q;
        price_d       = price_q;
        qty_d         = qty_q;
        product_d     = product_q;
        cnt_d         = cnt_q;
        total_d       = total_q;
        close_pend_d  = close_pend_q;
        overflow_d    = overflow_q;
        total_valid_d = total_valid_q;
        disc_en_d     = disc_en_q;

        sum    = {1'b0, total_q} + (TOT_W+1)'(product_q);
        addend = PROD_W'(price_q) << cnt_q;

        case (state_q)
            S_IDLE: begin
                if (item_valid) begin
                    price_d      = item_price;
                    qty_d        = item_qty;
                    product_d    = '0;
                    cnt_d        = '0;
                    close_pend_d = bill_close;
                    state_d      = S_MUL;
                end else if (bill_close) begin
                    total_valid_d = 1'b1;
                    disc_en_d     = (total_q >= THRESH);
                    state_d       = S_DONE;
                end
            end
            S_MUL: begin
                if (qty_q[cnt_q]) begin
                    product_d = product_q + addend;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (bill_close) begin
                    close_pend_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // The carry bit of the widened sum is exactly the saturation condition.
                total_d      = sum[TOT_W] ? TOT_MAX : sum[TOT_W-1:0];
                overflow_d   = overflow_q | sum[TOT_W];
                close_pend_d = 1'b0;
                if (close_pend_q || bill_close) begin
                    total_valid_d = 1'b1;
                    disc_en_d     = (total_d >= THRESH);
                    state_d       = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (out_ack) begin
                    total_d       = '0;
                    overflow_d    = 1'b0;
                    total_valid_d = 1'b0;
                    disc_en_d     = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            price_q       <= '0;
            qty_q         <= '0;
            product_q     <= '0;
            cnt_q         <= '0;
            total_q       <= '0;
            close_pend_q  <= 1'b0;
            overflow_q    <= 1'b0;
            total_valid_q <= 1'b0;
            disc_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            price_q       <= price_d;
            qty_q         <= qty_d;
            product_q     <= product_d;
            cnt_q         <= cnt_d;
            total_q       <= total_d;
            close_pend_q  <= close_pend_d;
            overflow_q    <= overflow_d;
            total_valid_q <= total_valid_d;
            disc_en_q     <= disc_en_d;
        end
    end

    assign item_ready  = (state_q == S_IDLE) && !rst;
    assign total       = total_q;
    assign total_valid = total_valid_q;
    assign disc_en     = disc_en_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bill_accumulator.sv
// Self-checking bench for bill_accumulator: directed scenarios plus randomized bills
// compared against an arithmetic model of the bill (sum of price*qty, saturating at 8191).
module tb_bill_accumulator;

    localparam int PRICE_W = 8;
    localparam int QTY_W   = 4;
    localparam int TOT_W   = 13;
    localparam int TOT_MAX = 8191;
    localparam int THRESH  = 2000;

    logic               clk = 1'b0;
    logic               rst;
    logic               item_valid;
    logic [PRICE_W-1:0] item_price;
    logic [QTY_W-1:0]   item_qty;
    logic               item_ready;
    logic               bill_close;
    logic [TOT_W-1:0]   total;
    logic               total_valid;
    logic               disc_en;
    logic               overflow;
    logic               out_ack;

    int checks = 0;
    int errors = 0;

    // Bill model and scoreboard of expected closed totals.
    int exp_total;
    bit exp_ovf;
    logic [TOT_W-1:0] exp_q[$];

    bill_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .item_valid  (item_valid),
        .item_price  (item_price),
        .item_qty    (item_qty),
        .item_ready  (item_ready),
        .bill_close  (bill_close),
        .total       (total),
        .total_valid (total_valid),
        .disc_en     (disc_en),
        .overflow    (overflow),
        .out_ack     (out_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        exp_total = 0;
        exp_ovf   = 1'b0;
    endfunction

    function automatic void model_add(input int p, input int q);
        exp_total = exp_total + p * q;
        if (exp_total > TOT_MAX) begin
            exp_total = TOT_MAX;
            exp_ovf   = 1'b1;
        end
    endfunction

    // Drivers: all run in the phase 1ns after a rising edge.
    task automatic send_item(input int p, input int q, input bit with_close);
        int n = 0;
        while (!item_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!item_ready) begin
            errors++;
            $display("FAIL item_ready_timeout: got %0b expected 1", item_ready);
        end
        item_valid = 1'b1;
        item_price = PRICE_W'(p);
        item_qty   = QTY_W'(q);
        bill_close = with_close;
        @(posedge clk); #1;
        item_valid = 1'b0;
        bill_close = 1'b0;
    endtask

    task automatic pulse_close();
        bill_close = 1'b1;
        @(posedge clk); #1;
        bill_close = 1'b0;
    endtask

    task automatic pulse_ack();
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (total !== '0 || total_valid !== 1'b0 || disc_en !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got total=%0d tv=%0b de=%0b ov=%0b expected 0 0 0 0",
                     total, total_valid, disc_en, overflow);
        end
        checks++;
        if (item_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %0b expected 0", item_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (item_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %0b expected 1", item_ready);
        end
    endtask

    task automatic test_single_item();
        model_clear();
        model_add(100, 3);
        send_item(100, 3, 1'b0);
        pulse_close();                    // arrives during the first MUL cycle
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (total !== '0) begin
            errors++;
            $display("FAIL single_early: got %0d expected 0", total);
        end
        @(posedge clk); #1;
        checks++;
        if (total !== TOT_W'(exp_total) || exp_total != 300) begin
            errors++;
            $display("FAIL single_total: got %0d expected 300", total);
        end
        checks++;
        if (total_valid !== 1'b1 || disc_en !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_flags: got tv=%0b de=%0b ov=%0b expected 1 0 0",
                     total_valid, disc_en, overflow);
        end
        pulse_ack();
        checks++;
        if (total !== '0 || total_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got total=%0d tv=%0b expected 0 0", total, total_valid);
        end
    endtask

    task automatic test_discount();
        int prices[3] = '{250, 200, 100};
        int qtys[3]   = '{4, 5, 1};
        model_clear();
        for (int i = 0; i < 3; i++) begin
            send_item(prices[i], qtys[i], 1'b0);
            model_add(prices[i], qtys[i]);
            repeat (QTY_W + 1) begin @(posedge clk); #1; end
            checks++;
            if (total !== TOT_W'(exp_total)) begin
                errors++;
                $display("FAIL discount_item%0d: got %0d expected %0d", i, total, exp_total);
            end
        end
        pulse_close();
        checks++;
        if (total !== 13'd2100 || total_valid !== 1'b1 || disc_en !== 1'b1) begin
            errors++;
            $display("FAIL discount_close: got total=%0d tv=%0b de=%0b expected 2100 1 1",
                     total, total_valid, disc_en);
        end
        checks++;
        if ((total >> 2) !== 13'd525) begin
            errors++;
            $display("FAIL discount_quarter: got %0d expected 525", total >> 2);
        end
        pulse_ack();
        checks++;
        if (total !== '0 || disc_en !== 1'b0 || total_valid !== 1'b0) begin
            errors++;
            $display("FAIL discount_ack: got total=%0d de=%0b tv=%0b expected 0 0 0",
                     total, disc_en, total_valid);
        end
    endtask

    task automatic test_saturation();
        int spec_tot[4] = '{3825, 7650, 8191, 8191};
        model_clear();
        for (int i = 0; i < 4; i++) begin
            send_item(255, 15, 1'b0);
            model_add(255, 15);
            repeat (QTY_W + 1) begin @(posedge clk); #1; end
            checks++;
            if (total !== TOT_W'(spec_tot[i]) || total !== TOT_W'(exp_total)) begin
                errors++;
                $display("FAIL saturation_total%0d: got %0d expected %0d", i, total, spec_tot[i]);
            end
            checks++;
            if (overflow !== exp_ovf) begin
                errors++;
                $display("FAIL saturation_ovf%0d: got %0b expected %0b", i, overflow, exp_ovf);
            end
        end
        pulse_close();
        checks++;
        if (total_valid !== 1'b1 || disc_en !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL saturation_close: got tv=%0b de=%0b ov=%0b expected 1 1 1",
                     total_valid, disc_en, overflow);
        end
        pulse_ack();
        checks++;
        if (overflow !== 1'b0 || total !== '0) begin
            errors++;
            $display("FAIL saturation_ack: got ov=%0b total=%0d expected 0 0", overflow, total);
        end
    endtask

    task automatic test_close_with_item();
        send_item(10, 2, 1'b1);
        repeat (QTY_W + 1) begin @(posedge clk); #1; end
        checks++;
        if (total !== 13'd20 || total_valid !== 1'b1 || disc_en !== 1'b0) begin
            errors++;
            $display("FAIL close_with_item: got total=%0d tv=%0b de=%0b expected 20 1 0",
                     total, total_valid, disc_en);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (total_valid !== 1'b1 || item_ready !== 1'b0) begin
            errors++;
            $display("FAIL close_with_item_hold: got tv=%0b rdy=%0b expected 1 0",
                     total_valid, item_ready);
        end
        pulse_ack();
        checks++;
        if (item_ready !== 1'b1 || total_valid !== 1'b0) begin
            errors++;
            $display("FAIL close_with_item_ack: got rdy=%0b tv=%0b expected 1 0",
                     item_ready, total_valid);
        end
    endtask

    task automatic test_empty_close();
        pulse_close();
        checks++;
        if (total_valid !== 1'b1 || total !== '0 || disc_en !== 1'b0) begin
            errors++;
            $display("FAIL empty_close: got tv=%0b total=%0d de=%0b expected 1 0 0",
                     total_valid, total, disc_en);
        end
        item_valid = 1'b1;
        item_price = 8'd99;
        item_qty   = 4'd9;
        bill_close = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (item_ready !== 1'b0 || total !== '0 || total_valid !== 1'b1) begin
            errors++;
            $display("FAIL empty_done_ignore: got rdy=%0b total=%0d tv=%0b expected 0 0 1",
                     item_ready, total, total_valid);
        end
        item_valid = 1'b0;
        bill_close = 1'b0;
        pulse_ack();
        checks++;
        if (item_ready !== 1'b1 || total_valid !== 1'b0 || total !== '0) begin
            errors++;
            $display("FAIL empty_ack: got rdy=%0b tv=%0b total=%0d expected 1 0 0",
                     item_ready, total_valid, total);
        end
        repeat (QTY_W + 2) begin @(posedge clk); #1; end
        checks++;
        if (total !== '0 || item_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_no_latent: got total=%0d rdy=%0b expected 0 1", total, item_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        send_item(20, 3, 1'b0);
        repeat (QTY_W + 1) begin @(posedge clk); #1; end
        checks++;
        if (total !== 13'd60) begin
            errors++;
            $display("FAIL rstmul_pre: got %0d expected 60", total);
        end
        send_item(50, 7, 1'b0);
        @(posedge clk); #1;               // now in the second MUL cycle
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (total !== '0 || item_ready !== 1'b0 || total_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmul_reset: got total=%0d rdy=%0b tv=%0b ov=%0b expected 0 0 0 0",
                     total, item_ready, total_valid, overflow);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (item_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmul_ready: got %0b expected 1", item_ready);
        end
        repeat (QTY_W + 2) begin @(posedge clk); #1; end
        checks++;
        if (total !== '0) begin
            errors++;
            $display("FAIL rstmul_discard: got %0d expected 0", total);
        end
        send_item(1, 1, 1'b0);
        repeat (QTY_W + 1) begin @(posedge clk); #1; end
        checks++;
        if (total !== 13'd1) begin
            errors++;
            $display("FAIL rstmul_after: got %0d expected 1", total);
        end
        pulse_close();
        pulse_ack();
    endtask

    task automatic test_random_bills();
        for (int b = 0; b < 25; b++) begin
            int n;
            int mode;
            n    = $urandom_range(0, 5);
            mode = (n == 0) ? 0 : $urandom_range(0, 2);
            model_clear();
            for (int i = 0; i < n; i++) begin
                int p;
                int q;
                bit last;
                p    = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
                q    = $urandom_range(0, 15);
                last = (i == n - 1);
                model_add(p, q);
                send_item(p, q, last && mode == 1);
                if (last && mode == 2) begin
                    pulse_close();
                    repeat (QTY_W) begin @(posedge clk); #1; end
                end else begin
                    repeat (QTY_W + 1) begin @(posedge clk); #1; end
                end
                checks++;
                if (total !== TOT_W'(exp_total) || overflow !== exp_ovf) begin
                    errors++;
                    $display("FAIL random_item b%0d i%0d: got total=%0d ov=%0b expected %0d %0b",
                             b, i, total, overflow, exp_total, exp_ovf);
                end
            end
            exp_q.push_back(TOT_W'(exp_total));
            if (mode == 0) begin
                pulse_close();
            end
            begin
                logic [TOT_W-1:0] exp_closed;
                exp_closed = exp_q.pop_front();
                checks++;
                if (total_valid !== 1'b1 || total !== exp_closed ||
                    disc_en !== (int'(exp_closed) >= THRESH) || overflow !== exp_ovf) begin
                    errors++;
                    $display("FAIL random_close b%0d: got tv=%0b total=%0d de=%0b ov=%0b expected 1 %0d %0b %0b",
                             b, total_valid, total, disc_en, overflow, exp_closed,
                             int'(exp_closed) >= THRESH, exp_ovf);
                end
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            pulse_ack();
            checks++;
            if (total_valid !== 1'b0 || total !== '0 || item_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_ack b%0d: got tv=%0b total=%0d rdy=%0b expected 0 0 1",
                         b, total_valid, total, item_ready);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        item_valid = 1'b0;
        item_price = '0;
        item_qty   = '0;
        bill_close = 1'b0;
        out_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_item();
        test_discount();
        test_saturation();
        test_close_with_item();
        test_empty_close();
        test_reset_mid_mul();
        test_random_bills();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
